// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for a single-ported synchronous RAM.
// One access in flight at a time; the RAM read latency is absorbed here.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [1:0] LP_CNT_INIT = 2'(RD_LAT - 1);

    state_t              r_state, w_state_nxt;
    logic                r_last_b, w_last_b_nxt;
    logic                r_win_b, w_win_b_nxt;
    logic                r_we, w_we_nxt;
    logic [1:0]          r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_ram_address, w_ram_address_nxt;
    logic [DATA_W-1:0]   r_ram_data, w_ram_data_nxt;
    logic                r_ram_wren, w_ram_wren_nxt;
    logic                r_a_gnt, w_a_gnt_nxt;
    logic                r_b_gnt, w_b_gnt_nxt;
    logic                r_a_rvalid, w_a_rvalid_nxt;
    logic                r_b_rvalid, w_b_rvalid_nxt;
    logic [DATA_W-1:0]   r_a_rdata, w_a_rdata_nxt;
    logic [DATA_W-1:0]   r_b_rdata, w_b_rdata_nxt;
    logic                w_pick_b;

    // With both requesting, the port not granted last wins.
    assign w_pick_b = b_req && (!a_req || !r_last_b);

    always_comb begin
        w_state_nxt       = r_state;
        w_last_b_nxt      = r_last_b;
        w_win_b_nxt       = r_win_b;
        w_we_nxt          = r_we;
        w_cnt_nxt         = r_cnt;
        w_ram_address_nxt = r_ram_address;
        w_ram_data_nxt    = r_ram_data;
        w_ram_wren_nxt    = 1'b0;
        w_a_gnt_nxt       = 1'b0;
        w_b_gnt_nxt       = 1'b0;
        w_a_rvalid_nxt    = 1'b0;
        w_b_rvalid_nxt    = 1'b0;
        w_a_rdata_nxt     = r_a_rdata;
        w_b_rdata_nxt     = r_b_rdata;

        case (r_state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    w_state_nxt       = S_ISSUE;
                    w_last_b_nxt      = w_pick_b;
                    w_win_b_nxt       = w_pick_b;
                    w_we_nxt          = w_pick_b ? b_we : a_we;
                    w_ram_wren_nxt    = w_pick_b ? b_we : a_we;
                    w_ram_address_nxt = w_pick_b ? b_addr : a_addr;
                    w_ram_data_nxt    = w_pick_b ? b_wdata : a_wdata;
                    w_a_gnt_nxt       = !w_pick_b;
                    w_b_gnt_nxt       = w_pick_b;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_CNT_INIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_IDLE;
                    if (r_win_b) begin
                        w_b_rvalid_nxt = 1'b1;
                        w_b_rdata_nxt  = ram_q;
                    end else begin
                        w_a_rvalid_nxt = 1'b1;
                        w_a_rdata_nxt  = ram_q;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_last_b      <= 1'b1;
            r_win_b       <= 1'b0;
            r_we          <= 1'b0;
            r_cnt         <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_a_gnt       <= 1'b0;
            r_b_gnt       <= 1'b0;
            r_a_rvalid    <= 1'b0;
            r_b_rvalid    <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_b      <= w_last_b_nxt;
            r_win_b       <= w_win_b_nxt;
            r_we          <= w_we_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ram_address <= w_ram_address_nxt;
            r_ram_data    <= w_ram_data_nxt;
            r_ram_wren    <= w_ram_wren_nxt;
            r_a_gnt       <= w_a_gnt_nxt;
            r_b_gnt       <= w_b_gnt_nxt;
            r_a_rvalid    <= w_a_rvalid_nxt;
            r_b_rvalid    <= w_b_rvalid_nxt;
            r_a_rdata     <= w_a_rdata_nxt;
            r_b_rdata     <= w_b_rdata_nxt;
        end
    end

    assign a_gnt       = r_a_gnt;
    assign b_gnt       = r_b_gnt;
    assign a_rvalid    = r_a_rvalid;
    assign b_rvalid    = r_b_rvalid;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, timestamp-based reference model,
// directed scenarios with literal expectations, then random two-master traffic.
module tb_ram_port_arbiter;

    parameter int unsigned RD_LAT = 1;
    localparam int unsigned LAT   = 2 + RD_LAT;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wren;
    logic [15:0] a_rdata, b_rdata, ram_address, ram_data, ram_q;

    int n_checks = 0;
    int n_errors = 0;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return 16'h5A5A ^ a;
    endfunction

    // RAM: address/data sampled at the edge, q valid RD_LAT edges later.
    logic [15:0] ram_mem [logic [15:0]];
    logic [15:0] ram_p0, ram_p1;
    always @(posedge clock) begin
        logic [15:0] rd;
        rd = ram_mem.exists(ram_address) ? ram_mem[ram_address] : init_val(ram_address);
        if (ram_wren === 1'b1) ram_mem[ram_address] = ram_data;
        ram_p0 <= rd;
        ram_p1 <= ram_p0;
    end
    assign ram_q = (RD_LAT == 2) ? ram_p1 : ram_p0;

    // Reference: tracks when the arbiter becomes free and when read data is due.
    logic [15:0] ref_mem [logic [15:0]];
    int          m_edge = 0, m_done_edge = 0, m_rd_edge = 0;
    bit          m_busy = 0, m_last_b = 1, m_rd_pend = 0, m_rd_b = 0;
    logic [15:0] m_rd_addr;
    logic        exp_a_gnt = 0, exp_b_gnt = 0, exp_wren = 0, exp_a_rv = 0, exp_b_rv = 0;
    logic [15:0] exp_addr = '0, exp_data = '0, exp_a_rdata = '0, exp_b_rdata = '0;

    always @(posedge clock) begin
        bit wb, we;
        logic [15:0] v;
        m_edge++;
        exp_a_gnt = 0; exp_b_gnt = 0; exp_wren = 0; exp_a_rv = 0; exp_b_rv = 0;
        if (!reset) begin
            exp_addr = '0; exp_data = '0; exp_a_rdata = '0; exp_b_rdata = '0;
            m_last_b = 1; m_busy = 0; m_rd_pend = 0;
        end else begin
            if (m_rd_pend && m_edge == m_rd_edge) begin
                v = ref_mem.exists(m_rd_addr) ? ref_mem[m_rd_addr] : init_val(m_rd_addr);
                if (m_rd_b) begin exp_b_rv = 1; exp_b_rdata = v; end
                else        begin exp_a_rv = 1; exp_a_rdata = v; end
                m_rd_pend = 0;
            end
            if (m_busy) begin
                if (m_edge == m_done_edge) m_busy = 0;
            end else if (a_req || b_req) begin
                if (a_req && b_req) wb = !m_last_b;
                else                wb = b_req;
                we        = wb ? b_we : a_we;
                m_last_b  = wb;
                exp_a_gnt = !wb;
                exp_b_gnt = wb;
                exp_addr  = wb ? b_addr : a_addr;
                exp_data  = wb ? b_wdata : a_wdata;
                exp_wren  = we;
                m_busy    = 1;
                if (we) begin
                    ref_mem[exp_addr] = exp_data;
                    m_done_edge = m_edge + 1;
                end else begin
                    m_rd_pend   = 1;
                    m_rd_b      = wb;
                    m_rd_addr   = exp_addr;
                    m_rd_edge   = m_edge + 1 + int'(RD_LAT);
                    m_done_edge = m_rd_edge;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle boundary goes through here, so the model is compared each cycle.
    task automatic tick();
        @(negedge clock);
        check("a_gnt", a_gnt, exp_a_gnt);
        check("b_gnt", b_gnt, exp_b_gnt);
        check("ram_wren", ram_wren, exp_wren);
        check("ram_address", ram_address, exp_addr);
        check("ram_data", ram_data, exp_data);
        check("a_rvalid", a_rvalid, exp_a_rv);
        check("b_rvalid", b_rvalid, exp_b_rv);
        check("a_rdata", a_rdata, exp_a_rdata);
        check("b_rdata", b_rdata, exp_b_rdata);
    endtask

    task automatic do_read(input bit pb, input logic [15:0] addr, input logic [15:0] expv);
        if (pb) begin b_req = 1; b_we = 0; b_addr = addr; end
        else    begin a_req = 1; a_we = 0; a_addr = addr; end
        tick();
        check("rd_gnt", pb ? b_gnt : a_gnt, 1'b1);
        check("rd_wren", ram_wren, 1'b0);
        a_req = 0; b_req = 0;
        for (int k = 2; k <= int'(1 + RD_LAT); k++) begin
            tick();
            check("rd_early_rvalid", pb ? b_rvalid : a_rvalid, 1'b0);
        end
        tick();
        check("rd_rvalid", pb ? b_rvalid : a_rvalid, 1'b1);
        check("rd_other_rvalid", pb ? a_rvalid : b_rvalid, 1'b0);
        check("rd_rdata", pb ? b_rdata : a_rdata, expv);
    endtask

    initial begin
        logic [3:0] seq;
        int         ngnt;

        // Reset held with both ports requesting.
        a_req = 1; b_req = 1; a_we = 1; b_we = 1;
        tick();
        tick();
        check("rst_a_gnt", a_gnt, 1'b0);
        check("rst_b_gnt", b_gnt, 1'b0);
        check("rst_wren", ram_wren, 1'b0);
        check("rst_addr", ram_address, 16'h0000);
        check("rst_a_rdata", a_rdata, 16'h0000);
        reset = 1; a_req = 0; b_req = 0;
        tick();

        // Write A.
        a_req = 1; a_we = 1; a_addr = 16'h0001; a_wdata = 16'h0003;
        tick();
        check("wr_a_gnt", a_gnt, 1'b1);
        check("wr_b_gnt", b_gnt, 1'b0);
        check("wr_wren", ram_wren, 1'b1);
        check("wr_addr", ram_address, 16'h0001);
        check("wr_data", ram_data, 16'h0003);
        a_req = 0;
        tick();
        check("wr_gnt_drop", a_gnt, 1'b0);
        check("wr_wren_drop", ram_wren, 1'b0);
        check("wr_addr_hold", ram_address, 16'h0001);

        do_read(1'b0, 16'h0001, 16'h0003);
        do_read(1'b1, 16'h0000, 16'h5A5A);

        // Tie: both reading continuously.
        a_req = 1; a_we = 0; a_addr = 16'h0001;
        b_req = 1; b_we = 0; b_addr = 16'h0002;
        seq = '0; ngnt = 0;
        for (int k = 0; k < int'(4 * LAT); k++) begin
            tick();
            if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
                seq = {seq[2:0], b_gnt};
                ngnt++;
            end
            if (a_rvalid === 1'b1) check("tie_a_rdata", a_rdata, 16'h0003);
            if (b_rvalid === 1'b1) check("tie_b_rdata", b_rdata, 16'h5A58);
        end
        a_req = 0; b_req = 0;
        check("tie_grant_count", ngnt, 4);
        check("tie_grant_order", seq, 4'b0101);
        tick();

        // Reset while a read waits on the RAM.
        a_req = 1; a_we = 0; a_addr = 16'h0001;
        tick();
        check("rw_gnt", a_gnt, 1'b1);
        a_req = 0;
        tick();
        reset = 0;
        tick();
        reset = 1;
        check("rw_no_rvalid", a_rvalid, 1'b0);
        check("rw_rdata_cleared", a_rdata, 16'h0000);
        do_read(1'b0, 16'h0001, 16'h0003);

        // Random traffic from both masters.
        for (int k = 0; k < 2000; k++) begin
            if (!a_req || exp_a_gnt) begin
                a_req = ($urandom_range(0, 1) == 1);
                a_we = $urandom_range(0, 1); a_addr = 16'($urandom_range(0, 7));
                a_wdata = 16'($urandom);
            end
            if (!b_req || exp_b_gnt) begin
                b_req = ($urandom_range(0, 2) != 0);
                b_we = $urandom_range(0, 1); b_addr = 16'($urandom_range(0, 7));
                b_wdata = 16'($urandom);
            end
            tick();
        end
        a_req = 0; b_req = 0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-port front end placed directly upstream of the 16-bit synchronous RAM, which has ports address, clock, data, wren and q.
- Port A is the processor data path. Port B is a secondary master, such as a video fetch or loader.
- Both masters issue single-word read/write requests. The block grants them round-robin, drives the RAM pins from registers, absorbs the RAM read latency, and returns read data with a one-cycle valid pulse.
- Only one access is in flight at a time.

Parameters:
- ADDR_W, 16, width of the RAM address and of a_addr/b_addr.
- DATA_W, 16, width of the RAM data and q.
- RD_LAT, 1, RAM read latency: number of clock edges from the RAM sampling the address to q being valid. Legal values are 1 and 2.

Ports:
- clock  in  1  system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- a_req  in  1  port A request; held stable until a_gnt is seen.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A grant; one-cycle pulse.
- a_rvalid  out  1  port A read data valid; one-cycle pulse.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  DATA_W  from RAM q.

Behaviour:
- All outputs are registered.
- Reset: reset=0 at a rising edge forces the following regardless of state:
  - state IDLE;
  - every output 0 (ram_address, ram_data, ram_wren, gnt, rvalid, rdata);
  - round-robin pointer set to "last = B";
  - read-wait counter cleared.
- Reset mid-access: an in-flight read is discarded and produces no rvalid. A write whose ISSUE cycle was cut off is not guaranteed to reach the RAM.
- State machine:
  - IDLE: if a_req or b_req is high, select a winner. With one requester, that requester wins. With both, the port not granted last wins. At the edge:
    - ram_address/ram_data load the winner's addr/wdata;
    - ram_wren loads the winner's we;
    - the winner's gnt goes to 1;
    - the pointer records the winner;
    - go to ISSUE, remembering the winner and the direction.
    - With no request, stay in IDLE with ram_wren=0.
  - ISSUE (one cycle; the RAM samples its inputs at the edge ending it):
    - gnt returns to 0 and ram_wren returns to 0 at the edge;
    - on a write, go to IDLE;
    - on a read, go to WAIT with counter = RD_LAT-1.
  - WAIT: when the counter reaches 0, go to IDLE and at the same edge load the winner's rdata from ram_q and set its rvalid=1. Otherwise decrement the counter.
- rvalid is 1 for exactly one cycle. rdata holds its value until the next read to the same port completes.
- Handshake:
  - A request is accepted in the cycle gnt is high.
  - The requester must drop req, or change it for a new access, in the cycle after gnt.
  - A req still high in that cycle is treated as a new request.
  - Writes are fire-and-forget; no completion pulse.
- Timing (edge n = first edge that samples req high in IDLE):
  - gnt and the RAM pins are valid after edge n;
  - the RAM samples at n+1;
  - a write is back in IDLE after n+1, so the next grant can come at n+2;
  - a read's rvalid goes high after edge n+1+RD_LAT (3 cycles for RD_LAT=1), and the next grant can come at n+2+RD_LAT.
- ram_address and ram_data hold their last values outside ISSUE.
- Only the winning port's gnt/rvalid/rdata ever change. The other port's outputs are untouched.
- A request arriving while the machine is busy waits. It is not lost as long as the requester keeps req high.

Test Plan:
- Reset: reset=0 for 2 cycles with a_req=b_req=1 -> every output 0, no gnt, no ram_wren.
- Write A: a_req=1, a_we=1, a_addr=0x0001, a_wdata=0x0003 -> after edge n, a_gnt=1, ram_wren=1, ram_address=0x0001, ram_data=0x0003 for exactly one cycle; b_gnt stays 0.
- Read back A (RD_LAT=1): a_req=1, a_we=0, a_addr=0x0001 -> a_rvalid=1 with a_rdata=0x0003 for one cycle, 3 cycles after the request; a read of address 0x0000 after reset returns the RAM's initialised contents.
- Tie: a_req=b_req=1 held, both reads, A at 0x0001 and B at 0x0002 -> grants go A, B, A, B; each rvalid appears only on its own port with the correct data; a new grant appears only after the previous access completes.
- Reset in WAIT: assert reset=0 in the cycle after ISSUE of a read -> no rvalid, state IDLE, then a_req alone is granted normally.
- RD_LAT=2 build: read at 0x0001 -> rvalid 4 cycles after the request, with data equal to the value last written there.
